// File: rtl/ahb_mem_slave.sv
// AHB-Lite word-addressed memory responder with OKAY / two-cycle ERROR responses and write statistics.
// Optional wait states before every OKAY data phase are enabled with the AHB_SLAVE_WAIT_EN macro.
module ahb_mem_slave #(
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [1:0]  HTRANS,
    input  logic [31:0] HWDATA,
    output logic [31:0] HRDATA,
    output logic        HREADY,
    output logic        HRESP,
    output logic [15:0] o_wr_count,
    output logic [31:0] o_last_addr
);

    localparam int unsigned AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [1:0]  TRANS_NSEQ  = 2'b10;
    localparam logic [1:0]  TRANS_SEQ   = 2'b11;
    localparam logic [2:0]  SIZE_WORD   = 3'b010;
    localparam logic        RESP_OKAY   = 1'b0;
    localparam logic        RESP_ERROR  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_DATA = 3'd1,
        ST_ERR1 = 3'd2,
        ST_ERR2 = 3'd3
`ifdef AHB_SLAVE_WAIT_EN
        ,
        ST_WAIT = 3'd4
`endif
    } state_t;

    state_t      state_q, state_d, launch_state_s;
    logic [31:0] addr_q, addr_d;
    logic        write_q, write_d;
    logic        err_q, err_d;
    logic [15:0] wr_count_q, wr_count_d;
    logic [31:0] last_addr_q, last_addr_d;
    logic        accept_s;
    logic        wr_en_s;
    logic [31:0] mem_q [DEPTH];
`ifdef AHB_SLAVE_WAIT_EN
    logic [3:0]  wait_cnt_q, wait_cnt_d, launch_cnt_s;
`endif

    // Burst type carries no behaviour here; the wait parameter is only live with the macro.
    logic unused_s;
    assign unused_s = ^{HBURST, 4'(WAIT_CYCLES)};

    function automatic logic phase_err(input logic [2:0] size, input logic [31:0] addr);
        phase_err = (size != SIZE_WORD) || (addr >= 32'(DEPTH));
    endfunction

    // Accept NONSEQ/SEQ address phases only while the bus is ready.
    always_comb begin
        accept_s = HSEL && HREADY && ((HTRANS == TRANS_NSEQ) || (HTRANS == TRANS_SEQ));
    end

    // Where the FSM goes from a state that can take a new address phase.
    always_comb begin
        launch_state_s = ST_IDLE;
`ifdef AHB_SLAVE_WAIT_EN
        launch_cnt_s   = 4'd0;
`endif
        if (accept_s) begin
            if (phase_err(HSIZE, HADDR)) begin
                launch_state_s = ST_ERR1;
            end
`ifdef AHB_SLAVE_WAIT_EN
            else if (WAIT_CYCLES > 0) begin
                launch_state_s = ST_WAIT;
                launch_cnt_s   = 4'(WAIT_CYCLES);
            end
`endif
            else begin
                launch_state_s = ST_DATA;
            end
        end else begin
            launch_state_s = ST_IDLE;
        end
    end

    // Next-state, address-phase capture and write-completion bookkeeping.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        write_d     = write_q;
        err_d       = err_q;
        wr_count_d  = wr_count_q;
        last_addr_d = last_addr_q;
        wr_en_s     = 1'b0;
`ifdef AHB_SLAVE_WAIT_EN
        wait_cnt_d  = wait_cnt_q;
`endif
        if (accept_s) begin
            addr_d  = HADDR;
            write_d = HWRITE;
            err_d   = phase_err(HSIZE, HADDR);
        end else begin
            addr_d  = addr_q;
        end
        case (state_q)
            ST_IDLE, ST_ERR2: begin
                state_d = launch_state_s;
`ifdef AHB_SLAVE_WAIT_EN
                wait_cnt_d = launch_cnt_s;
`endif
            end
            ST_DATA: begin
                state_d = launch_state_s;
`ifdef AHB_SLAVE_WAIT_EN
                wait_cnt_d = launch_cnt_s;
`endif
                if (write_q) begin
                    wr_en_s     = 1'b1;
                    wr_count_d  = wr_count_q + 16'd1;
                    last_addr_d = addr_q;
                end else begin
                    wr_en_s     = 1'b0;
                end
            end
            ST_ERR1: begin
                state_d = ST_ERR2;
            end
`ifdef AHB_SLAVE_WAIT_EN
            ST_WAIT: begin
                wait_cnt_d = wait_cnt_q - 4'd1;
                if (wait_cnt_q <= 4'd1) begin
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_WAIT;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Bus response decode from the current data-phase state.
    always_comb begin
        HREADY = 1'b1;
        HRESP  = RESP_OKAY;
        HRDATA = 32'h0000_0000;
        case (state_q)
            ST_DATA: begin
                if (!write_q) begin
                    HRDATA = mem_q[addr_q[AW-1:0]];
                end else begin
                    HRDATA = 32'h0000_0000;
                end
            end
            ST_ERR1: begin
                HREADY = 1'b0;
                HRESP  = RESP_ERROR;
            end
            ST_ERR2: begin
                HRESP  = RESP_ERROR;
            end
`ifdef AHB_SLAVE_WAIT_EN
            ST_WAIT: begin
                HREADY = 1'b0;
            end
`endif
            default: begin
                HREADY = 1'b1;
            end
        endcase
    end

    // Control and statistics registers; reset drops any pending data phase.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= ST_IDLE;
            addr_q      <= 32'h0000_0000;
            write_q     <= 1'b0;
            err_q       <= 1'b0;
            wr_count_q  <= 16'd0;
            last_addr_q <= 32'h0000_0000;
`ifdef AHB_SLAVE_WAIT_EN
            wait_cnt_q  <= 4'd0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            write_q     <= write_d;
            err_q       <= err_d;
            wr_count_q  <= wr_count_d;
            last_addr_q <= last_addr_d;
`ifdef AHB_SLAVE_WAIT_EN
            wait_cnt_q  <= wait_cnt_d;
`endif
        end
    end

    // Memory array is deliberately left unreset.
    always_ff @(posedge HCLK) begin
        if (wr_en_s) begin
            mem_q[addr_q[AW-1:0]] <= HWDATA;
        end
    end

    assign o_wr_count  = wr_count_q;
    assign o_last_addr = last_addr_q;

endmodule

// File: tb/tb_ahb_mem_slave.sv
// Directed bench for ahb_mem_slave: a transfer-duration model checked every cycle plus literal expectations.
module tb_ahb_mem_slave;

    localparam int DEPTH = 64;
`ifdef AHB_SLAVE_WAIT_EN
    localparam int WAITC = 2;
`else
    localparam int WAITC = 0;
`endif
    localparam logic [1:0] T_IDLE = 2'b00;
    localparam logic [1:0] T_BUSY = 2'b01;
    localparam logic [1:0] T_NSEQ = 2'b10;
    localparam logic [1:0] T_SEQ  = 2'b11;
    localparam logic [2:0] SZ_W   = 3'b010;
    localparam logic [2:0] SZ_H   = 3'b001;
    localparam logic [2:0] B_SNG  = 3'b000;
    localparam logic [2:0] B_I4   = 3'b011;
    localparam logic [2:0] B_I8   = 3'b101;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b1;
    logic        HSEL, HWRITE;
    logic [31:0] HADDR, HWDATA, HRDATA, o_last_addr;
    logic [2:0]  HSIZE, HBURST;
    logic [1:0]  HTRANS;
    logic        HREADY, HRESP;
    logic [15:0] o_wr_count;

    int n_chk  = 0;
    int n_fail = 0;

    ahb_mem_slave #(.DEPTH(DEPTH), .WAIT_CYCLES(2)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE),
        .HSIZE(HSIZE), .HBURST(HBURST), .HTRANS(HTRANS), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
        .o_wr_count(o_wr_count), .o_last_addr(o_last_addr)
    );

    initial forever #5 HCLK = ~HCLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%08h required 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a pending data phase simply has a number of cycles left.
    logic        m_pend  = 1'b0;
    logic        m_write = 1'b0;
    logic        m_err   = 1'b0;
    logic [31:0] m_addr  = 32'd0;
    int          m_left  = 0;
    logic [15:0] m_cnt   = 16'd0;
    logic [31:0] m_last  = 32'd0;
    logic [31:0] mem_m [DEPTH];
    bit          mem_v [DEPTH];
    logic        e_ready, e_resp, e_rvalid;
    logic [31:0] e_rdata;
    logic        bad_s;

    always_comb begin
        e_ready  = 1'b1;
        e_resp   = 1'b0;
        e_rdata  = 32'd0;
        e_rvalid = 1'b1;
        if (m_pend) begin
            e_ready = (m_left == 1);
            e_resp  = m_err;
            if (!m_err && !m_write && m_left == 1) begin
                e_rdata  = mem_m[m_addr[5:0]];
                e_rvalid = mem_v[m_addr[5:0]];
            end
        end
    end

    always_comb bad_s = (HSIZE != SZ_W) || (HADDR >= 32'(DEPTH));

    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            m_pend <= 1'b0;
            m_left <= 0;
            m_cnt  <= 16'd0;
            m_last <= 32'd0;
        end else begin
            if (m_pend && m_left == 1 && !m_err && m_write) begin
                mem_m[m_addr[5:0]] <= HWDATA;
                mem_v[m_addr[5:0]] <= 1'b1;
                m_cnt  <= m_cnt + 16'd1;
                m_last <= m_addr;
            end
            if (e_ready && HSEL && (HTRANS == T_NSEQ || HTRANS == T_SEQ)) begin
                m_pend  <= 1'b1;
                m_addr  <= HADDR;
                m_write <= HWRITE;
                m_err   <= bad_s;
                m_left  <= bad_s ? 2 : WAITC + 1;
            end else if (!e_ready) begin
                m_left <= m_left - 1;
            end else begin
                m_pend <= 1'b0;
            end
        end
    end

    logic rdy_s = 1'b1;
    always @(negedge HCLK) rdy_s <= HREADY;

    // Per-cycle comparison against the model, away from the rising edge.
    always @(negedge HCLK) begin
        chk("hready", {31'd0, HREADY}, {31'd0, e_ready});
        chk("hresp", {31'd0, HRESP}, {31'd0, e_resp});
        if (e_rvalid) chk("hrdata", HRDATA, e_rdata);
        chk("wr_count", {16'd0, o_wr_count}, {16'd0, m_cnt});
        chk("last_addr", o_last_addr, m_last);
    end

    task automatic drive(input logic [1:0] tr, input logic [31:0] a, input logic wr,
                         input logic [2:0] sz, input logic [2:0] bu, input logic [31:0] wd);
        int n;
        HTRANS = tr; HADDR = a; HWRITE = wr; HSIZE = sz; HBURST = bu;
        n = 0;
        do begin
            @(posedge HCLK);
            n++;
        end while (!rdy_s && n < 64);
        if (!rdy_s) chk("accept_timeout", {31'd0, rdy_s}, 32'd1);
        #1;
        HWDATA = wd;
    endtask

    task automatic idle();
        drive(T_IDLE, 32'd0, 1'b0, SZ_W, B_SNG, 32'd0);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        do begin
            @(negedge HCLK);
            n++;
        end while (!HREADY && n < 64);
    endtask

    task automatic rd_chk(input logic [31:0] a, input logic [31:0] exp, input string name);
        drive(T_NSEQ, a, 1'b0, SZ_W, B_SNG, 32'd0);
        HTRANS = T_IDLE;
        wait_ready();
        chk(name, HRDATA, exp);
        chk({name, "_resp"}, {31'd0, HRESP}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual running required finished");
        $fatal(1, "watchdog");
    end

    initial begin
        HSEL = 1'b1; HTRANS = T_IDLE; HADDR = 32'd0; HWRITE = 1'b0;
        HSIZE = SZ_W; HBURST = B_SNG; HWDATA = 32'd0;
        HRESETn = 1'b0;
        @(negedge HCLK);
        chk("rst_hready", {31'd0, HREADY}, 32'd1);
        chk("rst_hresp", {31'd0, HRESP}, 32'd0);
        chk("rst_hrdata", HRDATA, 32'd0);
        chk("rst_count", {16'd0, o_wr_count}, 32'd0);
        chk("rst_last", o_last_addr, 32'd0);
        #7 HRESETn = 1'b1;
        @(posedge HCLK); #1;

        // SINGLE write then read
        drive(T_NSEQ, 32'd5, 1'b1, SZ_W, B_SNG, 32'h0000_00A5);
        idle();
        chk("single_count", {16'd0, o_wr_count}, 32'd1);
        chk("single_last", o_last_addr, 32'd5);
        rd_chk(32'd5, 32'h0000_00A5, "rd5");

        // Unselected transfer is ignored
        HSEL = 1'b0; HTRANS = T_NSEQ; HWRITE = 1'b1; HADDR = 32'd5; HWDATA = 32'h5A;
        repeat (2) @(posedge HCLK);
        #1 HSEL = 1'b1; HTRANS = T_IDLE;
        rd_chk(32'd5, 32'h0000_00A5, "rd5_hsel0");
        chk("hsel0_count", {16'd0, o_wr_count}, 32'd1);

        // INCR4 descending from 20
        for (int i = 0; i < 4; i++)
            drive((i == 0) ? T_NSEQ : T_SEQ, 32'd20 - 32'(i), 1'b1, SZ_W, B_I4, 32'h10 + 32'(i));
        idle();
        chk("incr4_count", {16'd0, o_wr_count}, 32'd5);
        chk("incr4_last", o_last_addr, 32'd17);
        rd_chk(32'd20, 32'h10, "rd20");
        rd_chk(32'd19, 32'h11, "rd19");
        rd_chk(32'd18, 32'h12, "rd18");
        rd_chk(32'd17, 32'h13, "rd17");

        // INCR8 from 40 with three BUSY cycles after beat 2
        for (int i = 0; i < 8; i++) begin
            drive((i == 0) ? T_NSEQ : T_SEQ, 32'd40 + 32'(i), 1'b1, SZ_W, B_I8, 32'h400 + 32'(i));
            if (i == 1) begin
                for (int b = 0; b < 3; b++) begin
                    HTRANS = T_BUSY;
                    @(posedge HCLK); #1;
                end
            end
        end
        idle();
        chk("incr8_count", {16'd0, o_wr_count}, 32'd13);
        chk("incr8_last", o_last_addr, 32'd47);
        rd_chk(32'd41, 32'h401, "rd41");
        rd_chk(32'd42, 32'h402, "rd42");
        rd_chk(32'd47, 32'h407, "rd47");

        // Out-of-range write: two-cycle ERROR
        drive(T_NSEQ, 32'd64, 1'b1, SZ_W, B_SNG, 32'hDEAD_BEEF);
        HTRANS = T_IDLE;
        @(negedge HCLK);
        chk("err1_hready", {31'd0, HREADY}, 32'd0);
        chk("err1_hresp", {31'd0, HRESP}, 32'd1);
        @(negedge HCLK);
        chk("err2_hready", {31'd0, HREADY}, 32'd1);
        chk("err2_hresp", {31'd0, HRESP}, 32'd1);
        @(posedge HCLK); #1;
        chk("err_count", {16'd0, o_wr_count}, 32'd13);

        // HALFWORD write must not touch memory
        drive(T_NSEQ, 32'd3, 1'b1, SZ_W, B_SNG, 32'h33);
        drive(T_NSEQ, 32'd3, 1'b1, SZ_H, B_SNG, 32'hBAD);
        idle();
        chk("half_count", {16'd0, o_wr_count}, 32'd14);
        rd_chk(32'd3, 32'h33, "rd3_after_half");

        // Decrement from 0 wraps to 0xFFFFFFFF and errors
        drive(T_NSEQ, 32'd0, 1'b1, SZ_W, B_SNG, 32'h1234);
        drive(T_SEQ, 32'hFFFF_FFFF, 1'b1, SZ_W, B_SNG, 32'h9999);
        idle();
        chk("wrap_count", {16'd0, o_wr_count}, 32'd15);
        chk("wrap_last", o_last_addr, 32'd0);
        rd_chk(32'd0, 32'h1234, "rd0");

        // Read-after-write, back to back
        drive(T_NSEQ, 32'd10, 1'b1, SZ_W, B_SNG, 32'hCAFE);
        drive(T_NSEQ, 32'd10, 1'b0, SZ_W, B_SNG, 32'd0);
        HTRANS = T_IDLE;
        wait_ready();
        chk("raw_rdata", HRDATA, 32'hCAFE);
        chk("raw_count", {16'd0, o_wr_count}, 32'd16);
        @(posedge HCLK); #1;

        // Reset during a pending write data phase
        drive(T_NSEQ, 32'd7, 1'b1, SZ_W, B_SNG, 32'h77);
        idle();
        chk("pre_rst_count", {16'd0, o_wr_count}, 32'd17);
        drive(T_NSEQ, 32'd7, 1'b1, SZ_W, B_SNG, 32'hDEAD);
        HTRANS = T_IDLE;
        #2 HRESETn = 1'b0;
        #1;
        chk("mid_rst_hready", {31'd0, HREADY}, 32'd1);
        chk("mid_rst_count", {16'd0, o_wr_count}, 32'd0);
        chk("mid_rst_last", o_last_addr, 32'd0);
        @(posedge HCLK);
        #3 HRESETn = 1'b1;
        @(posedge HCLK); #1;
        rd_chk(32'd7, 32'h77, "rd7_after_reset");
        chk("post_rst_count", {16'd0, o_wr_count}, 32'd0);

        repeat (2) @(posedge HCLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ahb_mem_slave.md
# ahb_mem_slave

AHB-Lite write/read responder that terminates the transfers issued by the CPU DMA master. It holds a word-addressed memory, accepts SINGLE and INCR/INCR4/8/16 bursts including BUSY cycles, and returns OKAY or two-cycle ERROR responses. It sits on the bus opposite the master and exposes write statistics to the verifier.

## Interface
- DEPTH, 64: memory size in 32-bit words; HADDR is a word index.
- WAIT_CYCLES, 2: wait states per data phase (0–15); only used with AHB_SLAVE_WAIT_EN.
- HCLK  in  1  bus clock; all state updates on the rising edge.
- HRESETn  in  1  active-low reset, asynchronous assert.
- HSEL  in  1  slave select.
- HADDR  in  32  word address.
- HWRITE  in  1  WRITE/READ.
- HSIZE  in  3  transfer size; only WORD is legal.
- HBURST  in  HBURST_Type  burst type; informational, not checked.
- HTRANS  in  HTRANS_state  IDLE/BUSY/NONSEQ/SEQ.
- HWDATA  in  32  write data, valid during the data phase.
- HRDATA  out  32  read data.
- HREADY  out  1  transfer done / slave ready.
- HRESP  out  HRESP_state  OKAY/ERROR.
- o_wr_count  out  16  number of completed OKAY writes, wrapping.
- o_last_addr  out  32  word index of the last completed OKAY write.

## Operation
- An address phase is accepted when HSEL=1, HREADY=1 and HTRANS is NONSEQ or SEQ at a rising edge. On acceptance, register addr_q, write_q and err_q.
- err_q=1 when HSIZE≠WORD or HADDR≥DEPTH.
- IDLE and BUSY address phases are not accepted. They cause no data phase and no write, and leave an outstanding data phase untouched.
- FSM states:
  - ST_IDLE: no pending data phase.
  - ST_WAIT: wait-state counting.
  - ST_DATA: final data-phase cycle.
  - ST_ERR1 and ST_ERR2: error response.
- FSM transitions on an accepted transfer:
  - err_q=1 → ST_ERR1.
  - Otherwise, WAIT_CYCLES>0 (macro on) → ST_WAIT.
  - Otherwise → ST_DATA.
- ST_WAIT: HREADY=0, HRESP=OKAY. Decrement the counter, then go to ST_DATA.
- ST_DATA: HREADY=1, HRESP=OKAY.
  - Write: mem[addr_q]←HWDATA at the closing edge; o_wr_count+1; o_last_addr←addr_q.
  - Read: HRDATA=mem[addr_q].
  - The same edge may accept the next address phase (pipelined, back-to-back).
- ST_ERR1: HREADY=0, HRESP=ERROR, no write.
- ST_ERR2: HREADY=1, HRESP=ERROR, no write. A new address phase may be accepted on this edge.
- Address phases presented while HREADY=0 are ignored; the master must hold them.
- Decrementing bursts (master steps HADDR by −1) need no special handling; each beat is indexed independently.
- Address 0 followed by 0xFFFFFFFF gives ERROR on the wrapped beat.
- A burst that runs off the top or bottom of memory errors only on the out-of-range beats.
- Memory contents are not reset.

## Timing
- Reset values: HREADY=1, HRESP=OKAY, HRDATA=0, o_wr_count=0, o_last_addr=0, FSM=ST_IDLE, counters 0.
- Asynchronous reset mid-transfer drops the pending data phase. No write occurs, and HREADY=1 immediately.
- Zero-wait latency:
  - Address phase in cycle N, data phase in cycle N+1.
  - Write data is stored at the end of N+1.
- Read-after-write to the same index in consecutive beats returns the new data. The write completes at the edge that starts the read data phase.
- HRDATA=0 outside ST_DATA reads.
- With the macro on, each OKAY data phase lasts WAIT_CYCLES+1 cycles.
- Error data phases always last 2 cycles, independent of waits.

## Configuration
- AHB_SLAVE_WAIT_EN defined: WAIT_CYCLES wait states are inserted before every OKAY data phase. ST_WAIT exists.
- AHB_SLAVE_WAIT_EN undefined: zero-wait OKAY always. WAIT_CYCLES is ignored and ST_WAIT is not compiled.

## Test plan
- SINGLE write of 0x0000_00A5 to index 5, then a read of 5: read data phase has HRDATA=0xA5, HRESP=OKAY; o_wr_count=1, o_last_addr=5.
- INCR4 write from index 20 descending, data 0x10..0x13 (macro off): mem[20..17]=0x10..0x13, HREADY always 1; o_wr_count=4.
- INCR8 from index 40 with BUSY ×3 after beat 2: no extra writes during BUSY; all 8 words land correctly; o_wr_count=8.
- Write to index 64 (DEPTH=64): HREADY 0 then 1 with HRESP=ERROR both cycles; memory unchanged; o_wr_count unchanged.
- HSIZE=HALFWORD write to index 3: two-cycle ERROR; mem[3] unchanged.
- Macro on, WAIT_CYCLES=2, SINGLE write: HREADY low for exactly 2 cycles, data stored on the 3rd data-phase edge.
- Reset asserted during ST_WAIT: HREADY=1 immediately; no write; o_wr_count=0.
